mostra_sequencia: RTL

MOSTRA_SEQUENCIA -- requirements
Module: mostra_sequencia

---
 rtl/mostra_sequencia.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mostra_sequencia.sv
// Plays back a stored sequence of one-hot LED patterns (addresses 0..rodada), each lit then dark.
// Optional cancel input enabled by defining MOSTRA_SEQUENCIA_CANCELA_EN.
module mostra_sequencia #(
    parameter int unsigned T_ACESO   = 50000000,
    parameter int unsigned T_APAGADO = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] rodada,
`ifdef MOSTRA_SEQUENCIA_CANCELA_EN
    input  logic       cancela,
`endif
    input  logic [3:0] mem_dado,
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

    localparam logic [25:0] CARGA_ACESO   = 26'(T_ACESO - 1);
    localparam logic [25:0] CARGA_APAGADO = 26'(T_APAGADO - 1);

    estado_t     state_reg, state_next;
    logic [25:0] timer_reg, timer_next;
    logic [3:0]  endereco_reg, endereco_next;
    logic [3:0]  led_reg, led_next;
    logic [3:0]  rodada_reg, rodada_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= INICIAL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_reg    <= '0;
            endereco_reg <= '0;
            led_reg      <= '0;
            rodada_reg   <= '0;
        end else begin
            timer_reg    <= timer_next;
            endereco_reg <= endereco_next;
            led_reg      <= led_next;
            rodada_reg   <= rodada_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        endereco_next = endereco_reg;
        led_next      = led_reg;
        rodada_next   = rodada_reg;
        case (state_reg)
            INICIAL: begin
                timer_next = '0;
                if (iniciar) begin
                    rodada_next   = rodada;
                    endereco_next = '0;
                    state_next    = CARREGA;
                end
            end
            CARREGA: begin
                led_next   = mem_dado;
                timer_next = CARGA_ACESO;
                state_next = ACESO;
            end
            ACESO: begin
                if (timer_reg == '0) begin
                    timer_next = CARGA_APAGADO;
                    state_next = APAGADO;
                end else begin
                    timer_next = timer_reg - 26'd1;
                end
            end
            APAGADO: begin
                if (timer_reg == '0) begin
                    // Last item reached: address never advances past the captured rodada.
                    if (endereco_reg == rodada_reg) begin
                        state_next = FIM;
                    end else begin
                        endereco_next = endereco_reg + 4'd1;
                        state_next    = CARREGA;
                    end
                end else begin
                    timer_next = timer_reg - 26'd1;
                end
            end
            FIM: begin
                timer_next = '0;
                state_next = INICIAL;
            end
            default: begin
                timer_next = '0;
                state_next = INICIAL;
            end
        endcase
`ifdef MOSTRA_SEQUENCIA_CANCELA_EN
        if (cancela && (state_reg == CARREGA || state_reg == ACESO || state_reg == APAGADO)) begin
            timer_next = '0;
            state_next = INICIAL;
        end
`endif
    end

    assign mem_endereco = endereco_reg;
    assign leds         = (state_reg == ACESO) ? led_reg : 4'b0000;
    assign ocupado      = (state_reg != INICIAL);
    assign pronto       = (state_reg == FIM);
    assign db_estado    = state_reg;

endmodule
